remote_transmitter: RTL

IR remote-control frame transmitter: accepts an 8-bit key code and serializes one frame per request onto a single-wire `serial` line, one bit per `clk` cycle. It is the transmit end of the existing `RemoteController` receiver. The frame is a 2-bit leader followed by address, inverted address, data and inverted data. It drives receiver benches and loopback tests, replacing hand-written bit files.

---
 rtl/remote_pkg.sv | 25 ++
 rtl/remote_transmitter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/remote_pkg.sv
// Shared definitions for the IR remote frame transmitter: state encoding,
// frame geometry and the frame builder used by the RTL and receiver models.
package remote_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_ADDR,
    S_ADDR_N,
    S_DATA,
    S_DATA_N,
    S_GUARD
  } state_t;

  localparam int LEAD_BITS  = 2;
  localparam int BYTE_BITS  = 8;
  localparam int FRAME_BITS = LEAD_BITS + 4 * BYTE_BITS;

  // Bit k of the result is the k-th bit on the wire.
  function automatic logic [FRAME_BITS-1:0] remote_frame(input logic [7:0] addr,
                                                         input logic [7:0] key);
    return {~key, key, ~addr, addr, 2'b00};
  endfunction

endpackage

// File: rtl/remote_transmitter.sv
// IR remote frame transmitter: leader, address, ~address, key, ~key, then guard.
// Optional back-to-back repeat while send is held: define REMOTE_TX_REPEAT_EN.
module remote_transmitter
  import remote_pkg::*;
#(
  parameter logic [7:0] ADDR       = 8'h00,
  parameter int         GUARD_BITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tecla,
  input  logic       send,
  output logic       serial,
  output logic       busy,
  output logic       done
);

  localparam int              GW         = (GUARD_BITS > 1) ? $clog2(GUARD_BITS) : 1;
  localparam logic [GW-1:0]   GUARD_LAST = GW'(GUARD_BITS - 1);
  localparam logic [2:0]      LEAD_LAST  = 3'(LEAD_BITS - 1);
  localparam logic [2:0]      BYTE_LAST  = 3'(BYTE_BITS - 1);

  state_t                  state, state_nxt;
  logic [2:0]              bit_cnt, bit_cnt_nxt;
  logic [GW-1:0]           guard_cnt, guard_cnt_nxt;
  logic [7:0]              key;
  logic                    arm;
  logic [FRAME_BITS-1:0]   shift;
  logic [FRAME_BITS-1:0]   frame_load;
  logic [7:0]              load_key;
  logic                    load, start, shift_en, repeat_go;
  logic                    serial_nxt, busy_nxt, done_nxt;

`ifdef REMOTE_TX_REPEAT_EN
  assign repeat_go = send;
`else
  assign repeat_go = 1'b0;
`endif

  // A repeat reloads from the latched key; a fresh start takes tecla directly.
  assign start      = (state == S_IDLE) && send && arm;
  assign load_key   = (state == S_GUARD) ? key : tecla;
  assign frame_load = remote_frame(ADDR, load_key);

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    guard_cnt_nxt = guard_cnt;
    load          = 1'b0;
    shift_en      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load        = 1'b1;
          state_nxt   = S_LEAD;
          bit_cnt_nxt = 3'd0;
        end
      end
      S_LEAD: begin
        shift_en = 1'b1;
        if (bit_cnt == LEAD_LAST) begin
          state_nxt   = S_ADDR;
          bit_cnt_nxt = 3'd0;
        end else begin
          bit_cnt_nxt = bit_cnt + 3'd1;
        end
      end
      S_ADDR, S_ADDR_N, S_DATA, S_DATA_N: begin
        shift_en    = 1'b1;
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (bit_cnt == BYTE_LAST) begin
          case (state)
            S_ADDR:   state_nxt = S_ADDR_N;
            S_ADDR_N: state_nxt = S_DATA;
            S_DATA:   state_nxt = S_DATA_N;
            default: begin
              state_nxt     = S_GUARD;
              guard_cnt_nxt = '0;
            end
          endcase
        end
      end
      S_GUARD: begin
        if (guard_cnt == GUARD_LAST) begin
          if (repeat_go) begin
            load        = 1'b1;
            state_nxt   = S_LEAD;
            bit_cnt_nxt = 3'd0;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          guard_cnt_nxt = guard_cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Ones are shifted in behind the frame, so the line idles high once drained.
  assign serial_nxt = load ? frame_load[0] : (shift_en ? shift[0] : 1'b1);
  assign busy_nxt   = (state_nxt != S_IDLE);
  assign done_nxt   = (state_nxt == S_GUARD) && (guard_cnt_nxt == GUARD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= 3'd0;
      guard_cnt <= '0;
      key       <= 8'h00;
      arm       <= 1'b1;
      serial    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      guard_cnt <= guard_cnt_nxt;
      serial    <= serial_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      if (start)
        key <= tecla;
      if (start)
        arm <= 1'b0;
      else if (!send)
        arm <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load)
      shift <= {1'b1, frame_load[FRAME_BITS-1:1]};
    else if (shift_en)
      shift <= {1'b1, shift[FRAME_BITS-1:1]};
  end

endmodule
